// File: rtl/map_reader_if.sv
// map_reader_if: level-load, ROM and tile-query signals between game logic, map ROM and map_reader
interface map_reader_if #(
  parameter int MAP_BITS = 600
);
  logic                load;
  logic [3:0]          level_in;
  logic [3:0]          rom_level;
  logic [MAP_BITS-1:0] rom_map;
  logic                map_ready;
  logic                load_err;
  logic                query_valid;
  logic [4:0]          query_row;
  logic [4:0]          query_col;
  logic                query_ready;
  logic                resp_valid;
  logic                resp_wall;
  modport master (
    output load, level_in, rom_map, query_valid, query_row, query_col,
    input  rom_level, map_ready, load_err, query_ready, resp_valid, resp_wall
  );
  modport slave (
    input  load, level_in, rom_map, query_valid, query_row, query_col,
    output rom_level, map_ready, load_err, query_ready, resp_valid, resp_wall
  );
endinterface

// File: rtl/map_reader.sv
// map_reader: fetches a level map from ROM and answers per-tile wall queries
module map_reader #(
  parameter int COLS        = 30,
  parameter int ROWS        = 20,
  parameter int MAP_BITS    = 600,
  parameter int NUM_LEVELS  = 3,
  parameter int ROM_LATENCY = 1
) (
  input logic       clk,
  input logic       rst_n,
  map_reader_if.slave bus
);
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] READY   = 2'd3;
  localparam int CW = $clog2(ROM_LATENCY + 1);
  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [MAP_BITS-1:0] map;
  logic                lvl_ok;
  logic                accept;
  logic                oob;
  logic [9:0]          idx;
  assign lvl_ok          = bus.level_in < 4'(NUM_LEVELS);
  assign bus.map_ready   = state == READY;
  assign bus.query_ready = state == READY && !bus.load;
  assign accept          = bus.query_valid && bus.query_ready;
  assign oob             = bus.query_row >= 5'(ROWS) || bus.query_col >= 5'(COLS);
  assign idx             = 10'(bus.query_row) * 10'(COLS) + 10'(bus.query_col);
  // load FSM: a valid load always restarts the fetch, invalid loads leave it untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= EMPTY;
      bus.rom_level <= '0;
      map           <= '0;
      cnt           <= '0;
    end else if (bus.load && lvl_ok) begin
      state         <= FETCH;
      bus.rom_level <= bus.level_in;
      cnt           <= '0;
    end else if (state == FETCH) begin
      cnt   <= cnt + 1'b1;
      state <= cnt == CW'(ROM_LATENCY - 1) ? CAPTURE : FETCH;
    end else if (state == CAPTURE) begin
      map   <= bus.rom_map;
      state <= READY;
    end
  end
  // load error pulse and one-cycle query response; tiles outside the map read as wall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.load_err   <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_wall  <= 1'b0;
    end else begin
      bus.load_err   <= bus.load && !lvl_ok;
      bus.resp_valid <= accept;
      if (accept) bus.resp_wall <= oob ? 1'b1 : map[idx];
    end
  end
endmodule

// File: tb/tb_map_reader.sv
// tb_map_reader: directed sequence with randomized maps and queries checked against a level-map model
module tb_map_reader;
  localparam int COLS = 30;
  localparam int ROWS = 20;
  localparam int MAP_BITS = 600;
  logic clk;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int cur = 0;
  int qr[$];
  int qc[$];
  logic [MAP_BITS-1:0] lvls [3];
  map_reader_if #(.MAP_BITS(MAP_BITS)) bus ();
  map_reader #(.COLS(COLS), .ROWS(ROWS), .MAP_BITS(MAP_BITS), .NUM_LEVELS(3), .ROM_LATENCY(1)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // ROM model: one cycle from rom_level change to valid rom_map
  always @(posedge clk) bus.rom_map <= bus.rom_level < 4'd3 ? lvls[bus.rom_level] : '0;
  function automatic logic exp_wall(int lvl, int r, int c);
    return (r >= ROWS || c >= COLS) ? 1'b1 : lvls[lvl][r * COLS + c];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic q_set(int r, int c);
    bus.query_valid = 1'b1;
    bus.query_row   = 5'(r);
    bus.query_col   = 5'(c);
  endtask
  task automatic add_rand(int n);
    for (int i = 0; i < n; i++) begin
      qr.push_back(int'($urandom_range(0, 21)));
      qc.push_back(int'($urandom_range(0, 31)));
    end
  endtask
  task automatic run_queries();
    q_set(qr[0], qc[0]);
    #1;
    check("query_ready", 32'(bus.query_ready), 1);
    for (int i = 0; i < qr.size(); i++) begin
      tick();
      if (i + 1 < qr.size()) q_set(qr[i + 1], qc[i + 1]);
      else bus.query_valid = 1'b0;
      check($sformatf("resp_valid(%0d,%0d)", qr[i], qc[i]), 32'(bus.resp_valid), 1);
      check($sformatf("resp_wall(%0d,%0d)", qr[i], qc[i]), 32'(bus.resp_wall), 32'(exp_wall(cur, qr[i], qc[i])));
    end
    tick();
    check("resp_valid_idle", 32'(bus.resp_valid), 0);
    qr.delete();
    qc.delete();
  endtask
  task automatic load_level(int lv);
    bus.load = 1'b1;
    bus.level_in = 4'(lv);
    tick();
    bus.load = 1'b0;
    check("rom_level", 32'(bus.rom_level), 32'(lv));
    check("map_ready_n", 32'(bus.map_ready), 0);
    tick();
    check("map_ready_n1", 32'(bus.map_ready), 0);
    tick();
    check("map_ready_n2", 32'(bus.map_ready), 1);
    cur = lv;
  endtask
  task automatic bad_load(int lv);
    bus.load = 1'b1;
    bus.level_in = 4'(lv);
    #1;
    check("bad_query_ready", 32'(bus.query_ready), 0);
    tick();
    bus.load = 1'b0;
    check("load_err_pulse", 32'(bus.load_err), 1);
    check("bad_map_ready", 32'(bus.map_ready), 1);
    check("bad_rom_level", 32'(bus.rom_level), 32'(cur));
    tick();
    check("load_err_clear", 32'(bus.load_err), 0);
    check("bad_map_ready2", 32'(bus.map_ready), 1);
  endtask
  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.level_in = '0;
    bus.query_valid = 1'b0;
    bus.query_row = '0;
    bus.query_col = '0;
    for (int i = 0; i < MAP_BITS; i++) lvls[0][i] = 1'($urandom_range(0, 1));
    lvls[1] = '0;
    lvls[1][COLS-1:0] = '1;
    lvls[2] = ~lvls[0];
    tick();
    tick();
    check("rst_map_ready", 32'(bus.map_ready), 0);
    check("rst_rom_level", 32'(bus.rom_level), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_wall", 32'(bus.resp_wall), 0);
    check("rst_load_err", 32'(bus.load_err), 0);
    check("rst_query_ready", 32'(bus.query_ready), 0);
    rst_n = 1'b1;
    tick();
    tick();
    load_level(1);
    qr = '{0, 1};
    qc = '{29, 0};
    run_queries();
    bad_load(3);
    bad_load(int'($urandom_range(3, 15)));
    add_rand(12);
    run_queries();
    bus.load = 1'b1;
    bus.level_in = 4'd0;
    tick();
    bus.level_in = 4'd2;
    tick();
    bus.load = 1'b0;
    check("restart_rom_level", 32'(bus.rom_level), 2);
    check("restart_ready0", 32'(bus.map_ready), 0);
    tick();
    check("restart_ready1", 32'(bus.map_ready), 0);
    tick();
    check("restart_ready2", 32'(bus.map_ready), 1);
    cur = 2;
    for (int c = 0; c < COLS; c++) begin
      qr.push_back(0);
      qc.push_back(c);
    end
    qr.push_back(20);
    qc.push_back(0);
    qr.push_back(0);
    qc.push_back(30);
    add_rand(20);
    run_queries();
    bus.load = 1'b1;
    bus.level_in = 4'd1;
    q_set(0, 5);
    #1;
    check("collide_query_ready", 32'(bus.query_ready), 0);
    tick();
    bus.load = 1'b0;
    check("collide_resp_valid", 32'(bus.resp_valid), 0);
    check("collide_map_ready", 32'(bus.map_ready), 0);
    tick();
    check("collide_held_resp", 32'(bus.resp_valid), 0);
    tick();
    check("collide_reload_ready", 32'(bus.map_ready), 1);
    cur = 1;
    tick();
    bus.query_valid = 1'b0;
    check("collide_late_valid", 32'(bus.resp_valid), 1);
    check("collide_late_wall", 32'(bus.resp_wall), 32'(exp_wall(cur, 0, 5)));
    bus.load = 1'b1;
    bus.level_in = 4'd2;
    tick();
    bus.load = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("fetch_rst_map_ready", 32'(bus.map_ready), 0);
    check("fetch_rst_rom_level", 32'(bus.rom_level), 0);
    check("fetch_rst_resp_valid", 32'(bus.resp_valid), 0);
    tick();
    tick();
    check("fetch_rst_abandoned", 32'(bus.map_ready), 0);
    load_level(1);
    add_rand(10);
    run_queries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
